// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared types and constants for the GRF write-trace block.
//   trace_entry_t        -- one captured register-file write {pc, rd, data}
//   TRACE_DEPTH_DEFAULT  -- default FIFO depth used by grf_wr_trace
package mips_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_entry_t;

  localparam int unsigned TRACE_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word fall-through FIFO of trace entries.
//   clk, clr_n  -- clock; asynchronous active-low clear (empties the FIFO)
//   push, din   -- write request and entry; ignored when full unless popping
//   ready       -- consumer accepts head entry (pop when valid)
//   valid, dout -- head entry available / head entry (zero when empty)
//   pop         -- a pop happens at the coming edge
//   count, full -- occupancy and full indication
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       push,
  input  trace_entry_t               din,
  input  logic                       ready,
  output logic                       valid,
  output trace_entry_t               dout,
  output logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid && ready;
  // A pop frees a slot at the same edge, so a full FIFO still accepts a push then.
  assign do_push = push && (!full || pop);
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grf_wr_trace.sv
// grf_wr_trace: captures general-register-file writes into a trace FIFO.
//   clk, clr_n          -- clock; asynchronous active-low clear
//   Regw, rd, data, PC  -- GRF write port being observed (writes to $0 ignored)
//   ovf_clr             -- synchronous clear of overflow (and drop_cnt)
//   trace_valid/ready   -- head-entry handshake; trace_pc/rd/data head fields
//   count               -- FIFO occupancy
//   overflow            -- sticky: a capture was dropped because the FIFO was full
//   drop_cnt            -- saturating dropped-capture count, present only when
//                          GRF_TRACE_DROP_CNT_EN is defined
module grf_wr_trace
  import mips_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    Regw,
  input  logic [4:0]              rd,
  input  logic [31:0]             data,
  input  logic [31:0]             PC,
  input  logic                    ovf_clr,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [31:0]             trace_pc,
  output logic [4:0]              trace_rd,
  output logic [31:0]             trace_data,
  output logic [$clog2(DEPTH):0]  count,
`ifdef GRF_TRACE_DROP_CNT_EN
  output logic [15:0]             drop_cnt,
`endif
  output logic                    overflow
);

  trace_entry_t cap_entry;
  trace_entry_t head;
  logic         capture;
  logic         full;
  logic         pop;
  logic         drop;

  assign capture        = Regw && (rd != 5'd0);
  assign cap_entry.pc   = PC;
  assign cap_entry.rd   = rd;
  assign cap_entry.data = data;
  assign drop           = capture && full && !pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (capture),
    .din   (cap_entry),
    .ready (trace_ready),
    .valid (trace_valid),
    .dout  (head),
    .pop   (pop),
    .count (count),
    .full  (full)
  );

  assign trace_pc   = head.pc;
  assign trace_rd   = head.rd;
  assign trace_data = head.data;

  // A drop at the same edge as ovf_clr takes priority so no loss goes unreported.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef GRF_TRACE_DROP_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_grf_wr_trace.sv
module tb_grf_wr_trace;
  import mips_trace_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          Regw = 1'b0;
  logic [4:0]    rd = '0;
  logic [31:0]   data = '0;
  logic [31:0]   PC = '0;
  logic          ovf_clr = 1'b0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_rd;
  logic [31:0]   trace_data;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef GRF_TRACE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  grf_wr_trace #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .Regw        (Regw),
    .rd          (rd),
    .data        (data),
    .PC          (PC),
    .ovf_clr     (ovf_clr),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .count       (count),
`ifdef GRF_TRACE_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned  passed = 0;
  int unsigned  total  = 0;
  trace_entry_t q[$];
  logic         exp_ovf = 1'b0;
  logic [15:0]  exp_dc  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    trace_entry_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
    chk({tag, "_valid"}, 64'(trace_valid), 64'(q.size() != 0));
    chk({tag, "_pc"},    64'(trace_pc),   64'(h.pc));
    chk({tag, "_rd"},    64'(trace_rd),   64'(h.rd));
    chk({tag, "_data"},  64'(trace_data), 64'(h.data));
    chk({tag, "_ovf"},   64'(overflow),   64'(exp_ovf));
`ifdef GRF_TRACE_DROP_CNT_EN
    chk({tag, "_dropcnt"}, 64'(drop_cnt), 64'(exp_dc));
`endif
  endtask

  // Drives one cycle of stimulus (called #1 after a posedge), updates the
  // scoreboard, compares popped entries before the edge and state after it.
  task automatic cycle(input string tag, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] p,
                       input logic rdy, input logic oc);
    logic cap, full, pop, drop;
    trace_entry_t e;
    Regw = w; rd = a; data = d; PC = p; trace_ready = rdy; ovf_clr = oc;
    #1;
    cap  = w && (a != 5'd0);
    full = (q.size() == DEPTH);
    pop  = rdy && (q.size() != 0);
    if (pop) begin
      e = q.pop_front();
      chk({tag, "_pop_valid"}, 64'(trace_valid), 64'(1));
      chk({tag, "_pop_pc"},    64'(trace_pc),    64'(e.pc));
      chk({tag, "_pop_rd"},    64'(trace_rd),    64'(e.rd));
      chk({tag, "_pop_data"},  64'(trace_data),  64'(e.data));
    end
    drop = cap && full && !pop;
    if (cap && !drop) begin
      e.pc = p; e.rd = a; e.data = d;
      q.push_back(e);
    end
    if (drop) begin
      exp_ovf = 1'b1;
      if (exp_dc != 16'hFFFF) exp_dc = exp_dc + 16'd1;
    end else if (oc) begin
      exp_ovf = 1'b0;
      exp_dc  = '0;
    end
    @(posedge clk); #1;
    Regw = 1'b0; trace_ready = 1'b0; ovf_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_ovf = 1'b0;
    exp_dc  = '0;
  endtask

  initial begin
    // Power-on reset
    #1 check_state("reset");
    repeat (2) @(posedge clk);
    #4 clr_n = 1'b1;
    @(posedge clk); #1;

    // Single capture visible right after its edge
    cycle("cap1", 1, 5'd5, 32'h0000_0004, 32'h0000_3000, 0, 0);
    chk("cap1_rd5", 64'(trace_rd), 64'd5);
    chk("cap1_pc3000", 64'(trace_pc), 64'h3000);
    // Write to $0 is not captured
    cycle("zero_reg", 1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004, 0, 0);
    // Hold while not ready, then pop
    cycle("hold", 0, 5'd1, 32'h1, 32'h1, 0, 0);
    cycle("pop1", 0, 5'd0, 32'h0, 32'h0, 1, 0);
    // Ready while empty has no effect
    cycle("rdy_empty", 0, 5'd0, 32'h0, 32'h0, 1, 0);

    // Ten captures into an 8-deep FIFO: two drops
    for (int i = 1; i <= 10; i++)
      cycle("fill", 1, 5'(i), 32'hA000_0000 + 32'(i), 32'h0000_4000 + 32'(4*i), 0, 0);
    chk("fill_count8", 64'(count), 64'd8);
    chk("fill_ovf", 64'(overflow), 64'd1);
    // ovf_clr with a simultaneous drop keeps overflow set
    cycle("clr_drop", 1, 5'd11, 32'hBAD0_0011, 32'h0000_4100, 0, 1);
    chk("clr_drop_ovf", 64'(overflow), 64'd1);
    cycle("clr_only", 0, 5'd0, 32'h0, 32'h0, 0, 1);
    // Full with capture and pop at the same edge
    cycle("full_swap", 1, 5'd20, 32'hC0DE_0020, 32'h0000_5000, 1, 0);
    chk("full_swap_cnt", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++)
      cycle("drain", 0, 5'd0, 32'h0, 32'h0, 1, 0);

    // Empty with capture and ready at the same edge: no same-edge pop
    cycle("empty_cap_rdy", 1, 5'd9, 32'h0000_0099, 32'h0000_6000, 1, 0);
    chk("empty_cap_cnt", 64'(count), 64'd1);
    cycle("empty_cap_pop", 0, 5'd0, 32'h0, 32'h0, 1, 0);

    // Asynchronous clear mid-cycle with entries pending
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1, 5'(i + 1), 32'(i), 32'h0000_7000 + 32'(4*i), 0, 0);
    Regw = 1'b1; rd = 5'd3; trace_ready = 1'b1;
    #3 clr_n = 1'b0;
    model_reset();
    #1 check_state("async_rst");
    @(posedge clk); #1;
    check_state("in_rst");
    Regw = 1'b0; trace_ready = 1'b0;
    #3 clr_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst", 1, 5'd7, 32'h0000_0777, 32'h0000_8000, 0, 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++)
      cycle("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            $urandom(), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
